// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the instruction-fetch and data-access sram-like
// channels into one sram-like master port with a single transaction in flight.
// Data wins arbitration, but after MAX_DATA_RUN consecutive data grants while
// a fetch is waiting, the next grant goes to the fetch channel.
module sram_like_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction-fetch channel
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data-access channel
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // merged master port towards the bridge
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_I  = 3'd1,
    ST_REQ_D  = 3'd2,
    ST_WAIT_I = 3'd3,
    ST_WAIT_D = 3'd4
  } state_t;

  localparam logic [3:0] LP_MAX_RUN = MAX_DATA_RUN[3:0];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_run;
  logic [3:0]  w_run_nxt;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_in_idle;
  logic        w_grant_d;
  logic        w_grant_i;

  // Grants exist only in IDLE and never while reset is held, so addr_ok stays low in reset.
  assign w_in_idle = resetn && (r_state == ST_IDLE);
  assign w_grant_d = w_in_idle && data_req && (!inst_req || (r_run < LP_MAX_RUN));
  assign w_grant_i = w_in_idle && !w_grant_d && inst_req;

  assign inst_addr_ok = w_grant_i;
  assign data_addr_ok = w_grant_d;

  // The master request fields always reflect the captured request.
  assign m_wr    = r_wr;
  assign m_size  = r_size;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

  // Starvation counter: counts data grants that bypassed a waiting fetch.
  always_comb begin
    w_run_nxt = r_run;
    if (w_grant_d && inst_req) begin
      if (r_run < LP_MAX_RUN) begin
        w_run_nxt = r_run + 4'd1;
      end else begin
        w_run_nxt = r_run;
      end
    end else if (w_grant_d || w_grant_i) begin
      w_run_nxt = 4'd0;
    end else begin
      w_run_nxt = r_run;
    end
  end

  // Next-state and handshake outputs; rdata is forced to 0 outside data_ok and for stores.
  always_comb begin
    w_state_nxt  = r_state;
    m_req        = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_REQ_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_REQ_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ_I: begin
        m_req = 1'b1;
        if (m_addr_ok && m_data_ok) begin
          inst_data_ok = 1'b1;
          inst_rdata   = m_rdata;
          w_state_nxt  = ST_IDLE;
        end else if (m_addr_ok) begin
          w_state_nxt = ST_WAIT_I;
        end else begin
          w_state_nxt = ST_REQ_I;
        end
      end
      ST_REQ_D: begin
        m_req = 1'b1;
        if (m_addr_ok && m_data_ok) begin
          data_data_ok = 1'b1;
          data_rdata   = r_wr ? 32'd0 : m_rdata;
          w_state_nxt  = ST_IDLE;
        end else if (m_addr_ok) begin
          w_state_nxt = ST_WAIT_D;
        end else begin
          w_state_nxt = ST_REQ_D;
        end
      end
      ST_WAIT_I: begin
        if (m_data_ok) begin
          inst_data_ok = 1'b1;
          inst_rdata   = m_rdata;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_I;
        end
      end
      ST_WAIT_D: begin
        if (m_data_ok) begin
          data_data_ok = 1'b1;
          data_rdata   = r_wr ? 32'd0 : m_rdata;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_D;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and run counter registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_run   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Capture the granted request; a fetch is always a word read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_grant_d) begin
      r_wr    <= data_wr;
      r_size  <= data_size;
      r_addr  <= data_addr;
      r_wdata <= data_wdata;
    end else if (w_grant_i) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd2;
      r_addr  <= inst_addr;
      r_wdata <= 32'd0;
    end else begin
      r_wr    <= r_wr;
      r_size  <= r_size;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

endmodule
